// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target register endpoint.
// Also holds the 3-input majority helper used by the optional bus glitch
// filter (I2C_TARGET_GLITCH_FILTER_EN).
package i2c_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_ADDR,
    ST_RX_BYTE,
    ST_ACK_RX,
    ST_TX_BYTE,
    ST_RX_MACK,
    ST_WAIT_STOP
  } i2c_tgt_state_t;

  localparam logic [4:0] STATUS_ADDR = 5'h1F;
  localparam logic       ACK_BIT     = 1'b0;
  localparam logic       NACK_BIT    = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_bus_sampler.sv
// Brings SCL/SDA into the clk domain and turns them into single-cycle
// event pulses: SCL rise/fall, START and STOP.
// With I2C_TARGET_GLITCH_FILTER_EN defined, a 3-sample majority vote sits
// behind each synchroniser so pulses of one clk are dropped, at the cost of
// one extra clk of latency on every event.
module i2c_bus_sampler
  import i2c_target_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_prev;
  logic       r_sda_prev;
  logic       w_scl;
  logic       w_sda;

  // Two-flop synchronisers; an idle bus is high, so reset to ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] r_scl_hist;
  logic [1:0] r_sda_hist;

  // Keep the two previous synchronised samples for the majority vote.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_hist <= 2'b11;
      r_sda_hist <= 2'b11;
    end else begin
      r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
    end
  end

  assign w_scl = maj3(r_scl_sync[1], r_scl_hist[0], r_scl_hist[1]);
  assign w_sda = maj3(r_sda_sync[1], r_sda_hist[0], r_sda_hist[1]);
`else
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  // Previous clean values, used to spot edges one clk at a time.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_prev;
  assign o_scl_fall = ~w_scl & r_scl_prev;
  assign o_start    = w_scl & r_scl_prev & ~w_sda & r_sda_prev;
  assign o_stop     = w_scl & r_scl_prev & w_sda & ~r_sda_prev;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target endpoint serving a small byte register file with an
// auto-incrementing pointer, also reachable through a cs/read/write MMIO port.
// Optional build macro: I2C_TARGET_GLITCH_FILTER_EN (bus glitch filter in
// i2c_bus_sampler).
module i2c_target_regs
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         REG_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_scl,
  inout  tri          sda,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  reg_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        busy
);

  localparam int         PW      = $clog2(REG_DEPTH);
  localparam logic [5:0] DEPTH_W = 6'(REG_DEPTH);

  i2c_tgt_state_t r_state, w_state_next;
  logic [7:0]     r_shift, w_shift_next;
  logic [3:0]     r_bitcnt, w_bitcnt_next;
  logic           r_rw, w_rw_next;
  logic           r_first, w_first_next;
  logic           r_mack, w_mack_next;
  logic [PW-1:0]  r_ptr, w_ptr_next;
  logic           r_sda_oe, w_sda_oe_next;
  logic           r_busy, w_busy_next;
  logic           w_i2c_we;
  logic [7:0]     r_regs      [REG_DEPTH];
  logic [7:0]     w_regs_next [REG_DEPTH];
  logic [7:0]     w_tx_byte;
  logic           w_mmio_hit;
  logic           w_sda;
  logic           w_scl_rise;
  logic           w_scl_fall;
  logic           w_start;
  logic           w_stop;
  logic           w_unused_wr;

  i2c_bus_sampler u_sampler (
    .clk        (clk),
    .reset      (reset),
    .i_scl      (i_scl),
    .i_sda      (sda),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  // Open-drain drive; reset releases the line combinationally.
  assign sda         = (r_sda_oe && !reset) ? 1'b0 : 1'bz;
  assign busy        = r_busy;
  assign w_tx_byte   = r_regs[r_ptr];
  assign w_mmio_hit  = ({1'b0, reg_addr} < DEPTH_W);
  assign w_unused_wr = ^wr_data[31:8];

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_shift  <= 8'h00;
      r_bitcnt <= 4'd0;
      r_rw     <= 1'b0;
      r_first  <= 1'b0;
      r_mack   <= NACK_BIT;
      r_ptr    <= '0;
      r_sda_oe <= 1'b0;
      r_busy   <= 1'b0;
      for (int i = 0; i < REG_DEPTH; i++) r_regs[i] <= 8'h00;
    end else begin
      r_state  <= w_state_next;
      r_shift  <= w_shift_next;
      r_bitcnt <= w_bitcnt_next;
      r_rw     <= w_rw_next;
      r_first  <= w_first_next;
      r_mack   <= w_mack_next;
      r_ptr    <= w_ptr_next;
      r_sda_oe <= w_sda_oe_next;
      r_busy   <= w_busy_next;
      r_regs   <= w_regs_next;
    end
  end

  // Bus FSM: START/STOP override everything, otherwise bits are taken on SCL
  // rise and SDA only changes on the clk after an SCL fall.
  always_comb begin
    w_state_next  = r_state;
    w_shift_next  = r_shift;
    w_bitcnt_next = r_bitcnt;
    w_rw_next     = r_rw;
    w_first_next  = r_first;
    w_mack_next   = r_mack;
    w_ptr_next    = r_ptr;
    w_sda_oe_next = r_sda_oe;
    w_busy_next   = r_busy;
    w_i2c_we      = 1'b0;
    if (w_start) begin
      w_state_next  = ST_ADDR;
      w_bitcnt_next = 4'd0;
      w_sda_oe_next = 1'b0;
    end else if (w_stop) begin
      w_state_next  = ST_IDLE;
      w_sda_oe_next = 1'b0;
      w_busy_next   = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR: begin
          if (w_scl_rise) begin
            w_shift_next  = {r_shift[6:0], w_sda};
            w_bitcnt_next = r_bitcnt + 4'd1;
          end else if (w_scl_fall && r_bitcnt == 4'd8) begin
            if (r_shift[7:1] == TARGET_ADDR) begin
              w_state_next  = ST_ACK_ADDR;
              w_sda_oe_next = 1'b1;
              w_busy_next   = 1'b1;
              w_rw_next     = r_shift[0];
            end else begin
              w_state_next = ST_WAIT_STOP;
            end
          end
        end
        ST_ACK_ADDR: begin
          if (w_scl_fall) begin
            w_bitcnt_next = 4'd0;
            if (r_rw) begin
              w_state_next  = ST_TX_BYTE;
              w_shift_next  = w_tx_byte;
              w_sda_oe_next = ~w_tx_byte[7];
              w_ptr_next    = r_ptr + 1'b1;
            end else begin
              w_state_next  = ST_RX_BYTE;
              w_sda_oe_next = 1'b0;
              w_first_next  = 1'b1;
            end
          end
        end
        ST_RX_BYTE: begin
          if (w_scl_rise) begin
            w_shift_next  = {r_shift[6:0], w_sda};
            w_bitcnt_next = r_bitcnt + 4'd1;
          end else if (w_scl_fall && r_bitcnt == 4'd8) begin
            w_state_next  = ST_ACK_RX;
            w_sda_oe_next = 1'b1;
          end
        end
        ST_ACK_RX: begin
          if (w_scl_fall) begin
            w_state_next  = ST_RX_BYTE;
            w_sda_oe_next = 1'b0;
            w_bitcnt_next = 4'd0;
            if (r_first) begin
              w_ptr_next   = r_shift[PW-1:0];
              w_first_next = 1'b0;
            end else begin
              w_i2c_we   = 1'b1;
              w_ptr_next = r_ptr + 1'b1;
            end
          end
        end
        ST_TX_BYTE: begin
          if (w_scl_rise) begin
            w_bitcnt_next = r_bitcnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bitcnt == 4'd8) begin
              w_state_next  = ST_RX_MACK;
              w_sda_oe_next = 1'b0;
              w_mack_next   = NACK_BIT;
            end else begin
              w_shift_next  = {r_shift[6:0], 1'b0};
              w_sda_oe_next = ~r_shift[6];
            end
          end
        end
        ST_RX_MACK: begin
          if (w_scl_rise) begin
            w_mack_next = w_sda;
          end else if (w_scl_fall) begin
            if (r_mack == ACK_BIT) begin
              w_state_next  = ST_TX_BYTE;
              w_shift_next  = w_tx_byte;
              w_sda_oe_next = ~w_tx_byte[7];
              w_bitcnt_next = 4'd0;
              w_ptr_next    = r_ptr + 1'b1;
            end else begin
              w_state_next = ST_WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Register file update; the I2C write is applied last so it wins a
  // same-cycle collision with an MMIO write.
  always_comb begin
    w_regs_next = r_regs;
    if (cs && write && w_mmio_hit) w_regs_next[reg_addr[PW-1:0]] = wr_data[7:0];
    if (w_i2c_we) w_regs_next[r_ptr] = r_shift;
  end

  // Registered MMIO read data, held between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= 32'h0;
    end else if (cs && read) begin
      if (w_mmio_hit)
        rd_data <= {24'h0, r_regs[reg_addr[PW-1:0]]};
      else if (reg_addr == STATUS_ADDR)
        rd_data <= {26'h0, r_busy, 1'b0, 4'(r_ptr)};
      else
        rd_data <= 32'h0;
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Self-checking bench for i2c_target_regs: a bus-level I2C master drives
// SCL/SDA, expected ACKs, read bytes and MMIO read data go into a scoreboard
// queue and are popped when the DUT produces them.
`timescale 1ns/1ps
module tb_i2c_target_regs;
  import i2c_target_pkg::*;

  localparam int Q = 8;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int SYNC_LAT = 3;
`else
  localparam int SYNC_LAT = 2;
`endif

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        scl     = 1'b1;
  logic        tbSdaOe = 1'b0;
  logic        cs      = 1'b0;
  logic        read    = 1'b0;
  logic        write   = 1'b0;
  logic [4:0]  regAddr = 5'h0;
  logic [31:0] wrData  = 32'h0;
  logic [31:0] rdData;
  logic        busy;
  wire         sda;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expQ[$];
  logic        watchDrive = 1'b0;
  int          driveSeen  = 0;
  logic        unusedBit;
  logic        ackBit;

  assign sda = tbSdaOe ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_target_regs dut (
    .clk      (clk),
    .reset    (reset),
    .i_scl    (scl),
    .sda      (sda),
    .cs       (cs),
    .read     (read),
    .write    (write),
    .reg_addr (regAddr),
    .wr_data  (wrData),
    .rd_data  (rdData),
    .busy     (busy)
  );

  // Free-running system clock.
  initial forever #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Flag any low level on SDA while the master has released it.
  always @(posedge clk) begin
    #2;
    if (watchDrive && !tbSdaOe && sda == 1'b0) driveSeen <= driveSeen + 1;
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input logic [31:0] v);
    expQ.push_back(v);
  endtask

  task automatic popCheck(input string tag, input logic [31:0] obs);
    if (expQ.size() == 0) checkOutput("scoreboard_underflow", 32'(expQ.size()), 32'd1);
    else checkOutput(tag, obs, expQ.pop_front());
  endtask

  task automatic applyStimulus(input logic c, input logic r, input logic w,
                               input logic [4:0] a, input logic [31:0] d);
    cs = c; read = r; write = w; regAddr = a; wrData = d;
  endtask

  task automatic mmioWrite(input logic [4:0] a, input logic [7:0] d);
    applyStimulus(1'b1, 1'b0, 1'b1, a, {24'h0, d});
    waitClk(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'h0, 32'h0);
  endtask

  task automatic mmioRead(input logic [4:0] a, input logic [31:0] exp, input string tag);
    pushExp(exp);
    applyStimulus(1'b1, 1'b1, 1'b0, a, 32'h0);
    waitClk(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'h0, 32'h0);
    popCheck(tag, rdData);
  endtask

  // One SCL clock; data changes while SCL is low, bus sampled mid-high.
  task automatic i2cBit(input logic b, input logic glitch, output logic r);
    tbSdaOe = !b;
    if (glitch) begin
      waitClk(Q/2);
      scl = 1'b1;
      waitClk(1);
      scl = 1'b0;
      waitClk(Q - Q/2 - 1);
    end else begin
      waitClk(Q);
    end
    scl = 1'b1;
    waitClk(Q);
    r = sda;
    waitClk(Q);
    scl = 1'b0;
    waitClk(Q);
  endtask

  task automatic i2cStart();
    tbSdaOe = 1'b0;
    waitClk(Q);
    scl = 1'b1;
    waitClk(Q);
    tbSdaOe = 1'b1;
    waitClk(Q);
    scl = 1'b0;
    waitClk(Q);
  endtask

  task automatic i2cStop();
    tbSdaOe = 1'b1;
    waitClk(Q);
    scl = 1'b1;
    waitClk(Q);
    tbSdaOe = 1'b0;
    waitClk(Q);
  endtask

  task automatic sendByte(input logic [7:0] data, input logic expAck, input string tag,
                          input int glitchAt);
    logic ack;
    pushExp({31'h0, expAck});
    for (int i = 7; i >= 0; i--) i2cBit(data[i], (i == glitchAt), unusedBit);
    i2cBit(1'b1, 1'b0, ack);
    popCheck(tag, {31'h0, ack});
  endtask

  task automatic recvByte(input logic [7:0] expData, input logic masterAck, input string tag);
    logic [7:0] got;
    logic       b;
    pushExp({24'h0, expData});
    for (int i = 7; i >= 0; i--) begin
      i2cBit(1'b1, 1'b0, b);
      got[i] = b;
    end
    i2cBit(masterAck, 1'b0, unusedBit);
    popCheck(tag, {24'h0, got});
  endtask

  initial begin
    // Reset state.
    waitClk(4);
    checkOutput("reset_sda_released", 32'(sda), 32'd1);
    reset = 1'b0;
    waitClk(2);
    checkOutput("reset_rd_data", rdData, 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_state_idle", 32'(dut.r_state), 32'(ST_IDLE));
    mmioRead(STATUS_ADDR, 32'h0, "reset_status");
    mmioRead(5'd3, 32'h0, "reset_reg3");

    // Write pointer 3, then two data bytes.
    i2cStart();
    sendByte(8'h84, 1'b0, "t1_addr_ack", -1);
    checkOutput("t1_busy_high", 32'(busy), 32'd1);
    sendByte(8'h03, 1'b0, "t1_ptr_ack", -1);
    sendByte(8'hA5, 1'b0, "t1_d0_ack", -1);
    sendByte(8'h5A, 1'b0, "t1_d1_ack", -1);
    i2cStop();
    waitClk(4);
    checkOutput("t1_busy_low", 32'(busy), 32'd0);
    mmioRead(5'd3, 32'hA5, "t1_reg3");
    mmioRead(5'd4, 32'h5A, "t1_reg4");
    mmioRead(STATUS_ADDR, 32'h05, "t1_status_ptr5");

    // Wrong address is NACKed and SDA is never driven.
    watchDrive = 1'b1;
    i2cStart();
    sendByte(8'h86, 1'b1, "t2_wrong_addr_nack", -1);
    checkOutput("t2_busy_stays_low", 32'(busy), 32'd0);
    i2cStop();
    watchDrive = 1'b0;
    checkOutput("t2_sda_never_driven", 32'(driveSeen), 32'd0);
    i2cStart();
    sendByte(8'h84, 1'b0, "t2_retry_addr_ack", -1);
    sendByte(8'h00, 1'b0, "t2_retry_ptr_ack", -1);
    i2cStop();
    mmioRead(STATUS_ADDR, 32'h00, "t2_status_ptr0");

    // Pointer write, repeated START, read with wrap.
    mmioWrite(5'd7, 8'h11);
    mmioWrite(5'd0, 8'h22);
    i2cStart();
    sendByte(8'h84, 1'b0, "t3_addr_w_ack", -1);
    sendByte(8'h07, 1'b0, "t3_ptr_ack", -1);
    i2cStart();
    sendByte(8'h85, 1'b0, "t3_addr_r_ack", -1);
    recvByte(8'h11, ACK_BIT, "t3_rd_reg7");
    recvByte(8'h22, NACK_BIT, "t3_rd_reg0_wrap");
    i2cStop();
    mmioRead(STATUS_ADDR, 32'h01, "t3_status_ptr1");

    // STOP in the middle of a data byte writes nothing.
    i2cStart();
    sendByte(8'h84, 1'b0, "t4_addr_ack", -1);
    sendByte(8'h02, 1'b0, "t4_ptr_ack", -1);
    for (int i = 0; i < 4; i++) i2cBit(1'b1, 1'b0, unusedBit);
    i2cStop();
    waitClk(4);
    checkOutput("t4_busy_low", 32'(busy), 32'd0);
    checkOutput("t4_state_idle", 32'(dut.r_state), 32'(ST_IDLE));
    mmioRead(5'd2, 32'h00, "t4_reg2_untouched");
    mmioRead(STATUS_ADDR, 32'h02, "t4_ptr_kept");

    // Same-cycle I2C and MMIO write to reg 2: I2C value wins.
    i2cStart();
    sendByte(8'h84, 1'b0, "t5_addr_ack", -1);
    sendByte(8'h02, 1'b0, "t5_ptr_ack", -1);
    for (int i = 7; i >= 0; i--) i2cBit(((8'h33 >> i) & 8'h01) != 8'h00, 1'b0, unusedBit);
    pushExp(32'h0);
    tbSdaOe = 1'b0;
    waitClk(Q);
    scl = 1'b1;
    waitClk(Q);
    ackBit = sda;
    waitClk(Q);
    scl = 1'b0;
    waitClk(SYNC_LAT);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd2, 32'h44);
    waitClk(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'h0, 32'h0);
    waitClk(Q - SYNC_LAT - 1);
    popCheck("t5_data_ack", {31'h0, ackBit});
    i2cStop();
    mmioRead(5'd2, 32'h33, "t5_collision_i2c_wins");
    mmioRead(STATUS_ADDR, 32'h03, "t5_status_ptr3");

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // One-clk SCL glitch inside the address byte is filtered out.
    i2cStart();
    sendByte(8'h84, 1'b0, "t6_glitch_addr_ack", 3);
    checkOutput("t6_glitch_busy_high", 32'(busy), 32'd1);
    i2cStop();
`endif

    // Reset while the DUT is driving ACK releases SDA at once.
    i2cStart();
    for (int i = 7; i >= 0; i--) i2cBit(((8'h84 >> i) & 8'h01) != 8'h00, 1'b0, unusedBit);
    tbSdaOe = 1'b0;
    waitClk(Q);
    checkOutput("t7_ack_driven", 32'(sda), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("t7_reset_releases_sda", 32'(sda), 32'd1);
    waitClk(2);
    reset = 1'b0;
    scl = 1'b1;
    waitClk(2 * Q);
    checkOutput("t7_busy_after_reset", 32'(busy), 32'd0);
    mmioRead(5'd3, 32'h00, "t7_regs_cleared");

    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
